axi_burst_mem: RTL and testbench

AXI_BURST_MEM -- requirements
Module: axi_burst_mem

---
 rtl/axi_burst_pkg.sv | 65 ++++++
 rtl/axi_burst_addr_gen.sv | 41 ++++
 rtl/axi_burst_mem.sv | 197 +++++++++++++++++++
 tb/tb_axi_burst_mem.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_pkg.sv
// -----------------------------------------------------------------------------
// axi_burst_pkg -- shared definitions for the AXI burst memory slice.
//
// Contents:
//   - burst-type and response encodings
//   - write/read FSM state enums
//   - default data width and beat size
//   - resolve_burst(): maps a requested burst type onto the one the channel
//     will actually walk, and flags bursts that must end in SLVERR
//
// Configuration macro:
//   AXI_WRAP_BURST_EN  - when defined, legal WRAP bursts are honoured; when
//                        undefined, burst type 2'b10 is treated as reserved.
// -----------------------------------------------------------------------------
package axi_burst_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_BEAT_BYTES = DEF_DATA_WIDTH / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  typedef struct packed {
    logic [1:0] burst;  // burst type the address generator will follow
    logic       err;    // whole burst answers SLVERR
  } burst_sel_t;

  // A WRAP burst is only legal for 2/4/8/16 beats starting on a beat
  // boundary; anything else (or WRAP with the feature off) walks as INCR.
  function automatic burst_sel_t resolve_burst(input logic [1:0]  burst,
                                               input logic [7:0]  len,
                                               input logic [31:0] addr,
                                               input int unsigned beat_bytes);
    burst_sel_t sel;
    logic       wrap_legal;
    wrap_legal = WRAP_EN &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
                 ((addr & (beat_bytes - 1)) == 32'd0);
    sel.burst = BURST_INCR;
    sel.err   = 1'b0;
    case (burst)
      BURST_FIXED: sel.burst = BURST_FIXED;
      BURST_INCR:  sel.burst = BURST_INCR;
      BURST_WRAP:  if (wrap_legal) sel.burst = BURST_WRAP;
                   else            sel.err   = 1'b1;
      BURST_RSVD:  sel.err = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen -- next beat address for one AXI channel.
//
// Ports:
//   addr      in  ADDR_WIDTH  current beat byte address
//   len       in  8           burst length minus one (sets the WRAP container)
//   burst     in  2           resolved burst type (FIXED / INCR / WRAP)
//   next_addr out ADDR_WIDTH  byte address of the following beat
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BEAT_BYTES = DEF_BEAT_BYTES
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [31:0]           span;

  // Container = (len+1) beats; the low bits inside it advance, the rest hold.
  assign incr_addr = addr + ADDR_WIDTH'(BEAT_BYTES);
  assign span      = (32'(len) + 32'd1) * BEAT_BYTES;
  assign wrap_mask = ADDR_WIDTH'(span - 32'd1);

  always_comb begin
    // NOTE: default assignment first so every path drives next_addr (no latch).
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_mem.sv
// -----------------------------------------------------------------------------
// axi_burst_mem -- AXI-style burst memory slave with independent write and
// read channels over a single DEPTH x DATA_WIDTH word array.
//
// Ports:
//   ACLK, ARESET                    clock, synchronous active-high reset
//   AW*: AWADDR AWLEN AWBURST AWVALID / AWREADY   write address channel
//   W*:  WDATA WLAST WVALID / WREADY              write data channel
//   B*:  BRESP BVALID / BREADY                    write response channel
//   AR*: ARADDR ARLEN ARBURST ARVALID / ARREADY   read address channel
//   R*:  RDATA RRESP RLAST RVALID / RREADY        read data channel
//
// Configuration macro: AXI_WRAP_BURST_EN enables WRAP bursts (see package).
// -----------------------------------------------------------------------------
module axi_burst_mem
  import axi_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned SHIFT      = $clog2(BEAT_BYTES);
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr, w_next;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err, w_ok, w_last_beat, w_beat_err;
  logic [IDX_W-1:0]      w_idx;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_next;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;
  logic                  r_err, r_ok;
  logic [IDX_W-1:0]      r_idx;

  burst_sel_t aw_sel, ar_sel;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a >> SHIFT) < DEPTH;
  endfunction

  assign aw_sel = resolve_burst(AWBURST, AWLEN, 32'(AWADDR), BEAT_BYTES);
  assign ar_sel = resolve_burst(ARBURST, ARLEN, 32'(ARADDR), BEAT_BYTES);

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BEAT_BYTES(BEAT_BYTES)) u_aw_gen (
    .addr(w_addr), .len(w_len), .burst(w_burst), .next_addr(w_next)
  );
  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BEAT_BYTES(BEAT_BYTES)) u_ar_gen (
    .addr(r_addr), .len(r_len), .burst(r_burst), .next_addr(r_next)
  );

  assign w_idx       = IDX_W'(w_addr >> SHIFT);
  assign w_ok        = in_range(w_addr);
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = !w_ok || (WLAST != w_last_beat);
  assign r_idx       = IDX_W'(r_addr >> SHIFT);
  assign r_ok        = in_range(r_addr) && !r_err;

  // Write channel FSM. Errors accumulate across beats so BRESP reflects the
  // whole burst; the final beat's own error is folded in as BRESP is set.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments for all registered state.
    if (ARESET) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_INCR;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (AWVALID) begin
          w_addr  <= AWADDR;
          w_len   <= AWLEN;
          w_burst <= aw_sel.burst;
          w_err   <= aw_sel.err;
          w_cnt   <= '0;
          AWREADY <= 1'b0;
          WREADY  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (WVALID) begin
          w_addr <= w_next;
          w_cnt  <= w_cnt + 8'd1;
          w_err  <= w_err | w_beat_err;
          if (w_last_beat) begin
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            w_state <= W_RESP;
          end
        end
        W_RESP: if (BREADY) begin
          BVALID  <= 1'b0;
          BRESP   <= RESP_OKAY;
          AWREADY <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; contents
  // survive ARESET, and a beat presented during reset is not written.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_state == W_DATA && WVALID && w_ok)
      mem[w_idx] <= WDATA;
  end

  // Read channel FSM. R_FETCH reads the array, so a same-cycle write to the
  // same word is seen only by a later fetch.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= RESP_OKAY;
      RDATA   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_INCR;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (ARVALID) begin
          r_addr  <= ARADDR;
          r_len   <= ARLEN;
          r_burst <= ar_sel.burst;
          r_err   <= ar_sel.err;
          r_cnt   <= '0;
          ARREADY <= 1'b0;
          r_state <= R_FETCH;
        end
        R_FETCH: begin
          RDATA   <= r_ok ? mem[r_idx] : '0;
          RRESP   <= r_ok ? RESP_OKAY : RESP_SLVERR;
          RLAST   <= (r_cnt == r_len);
          RVALID  <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          RVALID <= 1'b0;
          if (RLAST) begin
            RLAST   <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            r_addr  <= r_next;
            r_cnt   <= r_cnt + 8'd1;
            r_state <= R_FETCH;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_mem -- self-checking bench for axi_burst_mem (default params).
// A word-array model plus burst address arithmetic predicts every response.
// Honours AXI_WRAP_BURST_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_burst_mem;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
`ifdef AXI_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic          ACLK = 1'b0, ARESET = 1'b1;
  logic [AW-1:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]    AWLEN = '0, ARLEN = '0;
  logic [1:0]    AWBURST = '0, ARBURST = '0;
  logic          AWVALID = 1'b0, WLAST = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
  logic          ARVALID = 1'b0, RREADY = 1'b0;
  logic [DW-1:0] WDATA = '0;
  logic          AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [1:0]    BRESP, RRESP;
  logic [DW-1:0] RDATA;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] model_mem [DEPTH];

  always #5 ACLK = ~ACLK;

  axi_burst_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  // ---------------- reference model: burst rules as plain arithmetic --------
  function automatic bit wrap_ok(input logic [15:0] a, input logic [7:0] len);
    return WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15) && (a % 4 == 0);
  endfunction

  function automatic bit burst_err(input logic [1:0] b, input logic [15:0] a, input logic [7:0] len);
    return (b == RSVD) || (b == WRAP && !wrap_ok(a, len));
  endfunction

  function automatic logic [15:0] beat_addr(input logic [15:0] a, input logic [7:0] len,
                                            input logic [1:0] b, input int i);
    int span, base, off;
    if (b == FIXED) return a;
    if (b == WRAP && wrap_ok(a, len)) begin
      span = (int'(len) + 1) * 4;
      base = int'(a) - (int'(a) % span);
      off  = (int'(a) - base + i * 4) % span;
      return 16'(base + off);
    end
    return 16'(int'(a) + i * 4);
  endfunction

  // ---------------- bus-level stimulus with inline checks -------------------
  task automatic write_burst(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [31:0] base_data, input bit rand_data, input int early_last);
    bit exp_err;
    logic [15:0] a;
    logic [31:0] d;
    logic [1:0]  exp_resp;
    int t;
    exp_err = burst_err(burst, addr, len);
    @(negedge ACLK);
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
    n_cmp++;
    if (AWREADY !== 1'b1) begin n_err++; $display("FAIL aw_timeout: AWREADY=%b want 1", AWREADY); end
    @(negedge ACLK);
    AWVALID = 1'b0;
    n_cmp++;
    if (WREADY !== 1'b1) begin n_err++; $display("FAIL wready_latency: WREADY=%b want 1", WREADY); end
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin WVALID = 1'b0; @(negedge ACLK); end
      d = rand_data ? $urandom : base_data + 32'(i);
      a = beat_addr(addr, len, burst, i);
      WVALID = 1'b1; WDATA = d;
      WLAST  = (early_last >= 0) ? (i == early_last) : (i == int'(len));
      if (WLAST != (i == int'(len))) exp_err = 1'b1;
      if (int'(a >> 2) < DEPTH) model_mem[a >> 2] = d;
      else exp_err = 1'b1;
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    exp_resp = exp_err ? 2'b10 : 2'b00;
    n_cmp++;
    if (BVALID !== 1'b1 || BRESP !== exp_resp) begin
      n_err++; $display("FAIL bresp @%h: BVALID=%b BRESP=%b want 1/%b", addr, BVALID, BRESP, exp_resp);
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge ACLK);
      n_cmp++;
      if (BVALID !== 1'b1 || BRESP !== exp_resp) begin
        n_err++; $display("FAIL bresp_hold: BVALID=%b BRESP=%b want 1/%b", BVALID, BRESP, exp_resp);
      end
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    n_cmp++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      n_err++; $display("FAIL b_done: BVALID=%b AWREADY=%b want 0/1", BVALID, AWREADY);
    end
  endtask

  task automatic read_burst(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int stall_lo, input int stall_hi);
    bit bad;
    logic [15:0] a;
    logic [31:0] ed;
    logic [1:0]  er;
    logic        el;
    int t;
    bad = burst_err(burst, addr, len);
    @(negedge ACLK);
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
    n_cmp++;
    if (ARREADY !== 1'b1) begin n_err++; $display("FAIL ar_timeout: ARREADY=%b want 1", ARREADY); end
    @(negedge ACLK);
    ARVALID = 1'b0;
    n_cmp++;
    if (RVALID !== 1'b0) begin n_err++; $display("FAIL rvalid_early: RVALID=%b want 0", RVALID); end
    @(negedge ACLK);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (RVALID !== 1'b1 && t < 20) begin @(negedge ACLK); t++; end
      if (i == 0) begin
        n_cmp++;
        if (t != 0) begin n_err++; $display("FAIL rvalid_latency: %0d extra cycles want 0", t); end
      end
      a  = beat_addr(addr, len, burst, i);
      el = (i == int'(len));
      if (bad || int'(a >> 2) >= DEPTH) begin ed = '0; er = 2'b10; end
      else begin ed = model_mem[a >> 2]; er = 2'b00; end
      n_cmp++;
      if (RVALID !== 1'b1 || RDATA !== ed || RRESP !== er || RLAST !== el) begin
        n_err++;
        $display("FAIL rbeat%0d @%h: valid %b data %h resp %b last %b, want 1 %h %b %b",
                 i, a, RVALID, RDATA, RRESP, RLAST, ed, er, el);
      end
      repeat ($urandom_range(stall_lo, stall_hi)) begin
        @(negedge ACLK);
        n_cmp++;
        if (RVALID !== 1'b1 || RDATA !== ed || RRESP !== er || RLAST !== el) begin
          n_err++;
          $display("FAIL r_hold%0d: valid %b data %h resp %b last %b, want 1 %h %b %b",
                   i, RVALID, RDATA, RRESP, RLAST, ed, er, el);
        end
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    n_cmp++;
    if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
      n_err++; $display("FAIL r_done: ARREADY=%b RVALID=%b want 1/0", ARREADY, RVALID);
    end
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    logic [41:0] got, want;
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    got  = {AWREADY, ARREADY, WREADY, BVALID, BRESP, RVALID, RLAST, RRESP, RDATA};
    want = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0};
    n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_outputs: %h want %h", got, want); end
    ARESET = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_incr();
    logic [15:0] a;
    logic [7:0]  l;
    write_burst(16'h0000, 8'd255, INCR, 32'h0, 1'b1, -1);  // preload words 0..255
    write_burst(16'h0010, 8'd3, INCR, 32'hA0, 1'b0, -1);
    read_burst(16'h0010, 8'd3, INCR, 0, 1);
    for (int k = 0; k < 4; k++) begin
      a = 16'($urandom_range(0, 16'h03C0)) & 16'hFFFC;
      l = 8'($urandom_range(0, 7));
      write_burst(a, l, INCR, 32'h0, 1'b1, -1);
      read_burst(a, l, INCR, 0, 2);
    end
  endtask

  task automatic test_fixed();
    write_burst(16'h0020, 8'd2, FIXED, 32'h1, 1'b0, -1);
    read_burst(16'h0020, 8'd0, INCR, 5, 5);
    read_burst(16'h0020, 8'd2, FIXED, 0, 1);
  endtask

  task automatic test_boundary();
    write_burst(16'((DEPTH - 1) * 4), 8'd1, INCR, 32'h0, 1'b1, -1);
    read_burst(16'((DEPTH - 1) * 4), 8'd1, INCR, 0, 1);
    write_burst(16'h0040, 8'd3, INCR, 32'h0, 1'b1, 0);      // WLAST on beat 0
    read_burst(16'h0040, 8'd3, INCR, 0, 0);
    write_burst(16'hFFF8, 8'd3, INCR, 32'h0, 1'b1, -1);     // wraps past 0xFFFF
    read_burst(16'hFFF8, 8'd3, INCR, 0, 0);
  endtask

  task automatic test_wrap();
    write_burst(16'h0030, 8'd3, INCR, 32'hC0, 1'b0, -1);
    read_burst(16'h0038, 8'd3, WRAP, 0, 1);
    write_burst(16'h0078, 8'd7, WRAP, 32'h0, 1'b1, -1);
    read_burst(16'h0060, 8'd7, INCR, 0, 0);
    write_burst(16'h0088, 8'd2, WRAP, 32'h0, 1'b1, -1);     // illegal length
    read_burst(16'h0088, 8'd2, WRAP, 0, 0);
    write_burst(16'h00A0, 8'd1, RSVD, 32'h0, 1'b1, -1);
    read_burst(16'h00A0, 8'd1, RSVD, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d;
    bit          saw_b;
    int          t;
    @(negedge ACLK);
    AWADDR = 16'h0100; AWLEN = 8'd3; AWBURST = INCR; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      WVALID = 1'b1; WDATA = d; WLAST = 1'b0;
      model_mem[(16'h0100 >> 2) + i] = d;
      @(negedge ACLK);
    end
    WDATA = $urandom; ARESET = 1'b1;
    @(negedge ACLK);
    n_cmp++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0 || BVALID !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: AWREADY=%b WREADY=%b BVALID=%b want 1/0/0", AWREADY, WREADY, BVALID);
    end
    ARESET = 1'b0; WVALID = 1'b0;
    saw_b = 1'b0;
    repeat (10) begin
      BREADY = 1'b1;
      @(negedge ACLK);
      if (BVALID !== 1'b0) saw_b = 1'b1;
    end
    BREADY = 1'b0;
    n_cmp++;
    if (saw_b) begin n_err++; $display("FAIL no_resp_after_reset: BVALID seen=1 want 0"); end
    read_burst(16'h0100, 8'd1, INCR, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0]  l;
    logic [1:0]  b;
    for (int k = 0; k < 10; k++) begin
      b = 2'($urandom_range(0, 3));
      l = (b == WRAP) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 5));
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'h0FE0, 16'h1100))
                                      : 16'($urandom_range(0, 16'h03C0));
      if ($urandom_range(0, 3) != 0) a = a & 16'hFFFC;
      write_burst(a, l, b, 32'h0, 1'b1, -1);
      read_burst(a, l, b, 0, 1);
    end
    // Channels overlap in time on disjoint regions.
    fork
      write_burst(16'h0200, 8'd7, INCR, 32'h0, 1'b1, -1);
      read_burst(16'h0000, 8'd7, INCR, 0, 1);
    join
    read_burst(16'h0200, 8'd7, INCR, 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_incr();
    test_fixed();
    test_boundary();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
